// File: rtl/ysyx_25080199_pkg.sv
// Shared types and constants for the write-back unit.
// Load funct3 encodings and the WBU state typedef.
package ysyx_25080199_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/ysyx_25080199_load_ext.sv
// Sub-word load extraction and sign/zero extension.
// Reserved funct3 codes pass the whole word through.
module ysyx_25080199_load_ext
  import ysyx_25080199_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  // pick the lane and extend by load type
  always_comb begin
    ext = rdata;
    unique case (1'b1)
      (funct3 == LB):
        ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      (funct3 == LBU):
        ext = {{(XLEN-8){1'b0}}, byte_sel};
      (funct3 == LH):
        ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      (funct3 == LHU):
        ext = {{(XLEN-16){1'b0}}, half_sel};
      default:
        ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25080199_wbu.sv
// Write-back unit: retire handshake, load wait, RF write port.
// Define YSYX_25080199_WBU_BYPASS_EN to forward the pending write.
module ysyx_25080199_wbu
  import ysyx_25080199_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic            exu_wen,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            exu_is_load,
  input  logic [2:0]      exu_funct3,
  input  logic [1:0]      exu_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            reg_we,
  output logic [4:0]      reg_addr,
  output logic [XLEN-1:0] reg_data,
  input  logic [4:0]      idu_rs1_addr,
  input  logic [4:0]      idu_rs2_addr,
  output logic            idu_stall,
  output logic            byp_rs1_hit,
  output logic            byp_rs2_hit,
  output logic [XLEN-1:0] byp_data
);

  wbu_state_e      state;
  logic            busy;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic [XLEN-1:0] ld_ext;

  logic rs1_busy;
  logic rs2_busy;
  logic rs1_pend;
  logic rs2_pend;

  ysyx_25080199_load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .funct3 (ld_funct3),
    .addr_lo(ld_addr_lo),
    .rdata  (mem_rdata),
    .ext    (ld_ext)
  );

  assign exu_ready = (state == IDLE);

  // FSM, one-entry load scoreboard and RF write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      ld_rd      <= 5'd0;
      ld_funct3  <= 3'd0;
      ld_addr_lo <= 2'd0;
      reg_we     <= 1'b0;
      reg_addr   <= 5'd0;
      reg_data   <= '0;
    end else begin
      reg_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exu_valid) begin
            if (exu_is_load) begin
              ld_rd      <= exu_rd;
              ld_funct3  <= exu_funct3;
              ld_addr_lo <= exu_addr_lo;
              busy       <= exu_wen && (exu_rd != 5'd0);
              state      <= WAIT_MEM;
            end else begin
              reg_we   <= exu_wen && (exu_rd != 5'd0);
              reg_addr <= exu_rd;
              reg_data <= exu_data;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            reg_we   <= busy;
            reg_addr <= ld_rd;
            reg_data <= ld_ext;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  // hazard terms from registered state only
  always_comb begin
    rs1_busy = busy && (ld_rd == idu_rs1_addr)
               && (idu_rs1_addr != 5'd0);
    rs2_busy = busy && (ld_rd == idu_rs2_addr)
               && (idu_rs2_addr != 5'd0);
    rs1_pend = reg_we && (reg_addr == idu_rs1_addr)
               && (idu_rs1_addr != 5'd0);
    rs2_pend = reg_we && (reg_addr == idu_rs2_addr)
               && (idu_rs2_addr != 5'd0);
  end

`ifdef YSYX_25080199_WBU_BYPASS_EN
  assign byp_rs1_hit = rs1_pend;
  assign byp_rs2_hit = rs2_pend;
  assign byp_data    = reg_data;
  assign idu_stall   = rs1_busy || rs2_busy;
`else
  assign byp_rs1_hit = 1'b0;
  assign byp_rs2_hit = 1'b0;
  assign byp_data    = '0;
  assign idu_stall   = rs1_busy || rs2_busy
                       || rs1_pend || rs2_pend;
`endif

endmodule

// File: tb/tb_ysyx_25080199_wbu.sv
// Scoreboard bench for the write-back unit.
// Writes are queued on issue and checked by a monitor.
module tb_ysyx_25080199_wbu;

  logic        clk;
  logic        rst;
  logic        exu_valid;
  logic        exu_ready;
  logic        exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_is_load;
  logic [2:0]  exu_funct3;
  logic [1:0]  exu_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [4:0]  idu_rs1_addr;
  logic [4:0]  idu_rs2_addr;
  logic        idu_stall;
  logic        byp_rs1_hit;
  logic        byp_rs2_hit;
  logic [31:0] byp_data;

  int n_chk;
  int n_pass;

  logic [36:0] sb_q[$];

`ifdef YSYX_25080199_WBU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ysyx_25080199_wbu #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_wen     (exu_wen),
    .exu_rd      (exu_rd),
    .exu_data    (exu_data),
    .exu_is_load (exu_is_load),
    .exu_funct3  (exu_funct3),
    .exu_addr_lo (exu_addr_lo),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .idu_rs1_addr(idu_rs1_addr),
    .idu_rs2_addr(idu_rs2_addr),
    .idu_stall   (idu_stall),
    .byp_rs1_hit (byp_rs1_hit),
    .byp_rs2_hit (byp_rs2_hit),
    .byp_data    (byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  // monitor: every RF write must match the queue head
  always @(negedge clk) begin
    if (!rst && reg_we) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {27'd0, reg_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("wr_addr", {27'd0, reg_addr}, {27'd0, e[36:32]});
        check("wr_data", reg_data, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [4:0] rd,
                       input logic [31:0] data,
                       input logic ld, input logic [2:0] f3,
                       input logic [1:0] alo);
    check("ready_before_issue", {31'd0, exu_ready}, 32'd1);
    exu_valid   = 1'b1;
    exu_wen     = wen;
    exu_rd      = rd;
    exu_data    = data;
    exu_is_load = ld;
    exu_funct3  = f3;
    exu_addr_lo = alo;
    if (!ld && wen && rd != 5'd0)
      sb_q.push_back({rd, data});
    tick();
    exu_valid = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] alo,
                         input logic [31:0] rdata,
                         input int dly, input logic [31:0] exp);
    logic dep;
    dep = (rd != 5'd0) && (idu_rs1_addr == rd);
    issue(1'b1, rd, 32'hDEAD_BEEF, 1'b1, f3, alo);
    // a competing retire held on the port must not be taken
    exu_valid   = 1'b1;
    exu_is_load = 1'b0;
    exu_wen     = 1'b1;
    exu_rd      = 5'd9;
    exu_data    = 32'h0000_0BAD;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("ld_wait_ready", {31'd0, exu_ready}, 32'd0);
      if (dep) check("ld_wait_stall", {31'd0, idu_stall}, 32'd1);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    if (rd != 5'd0) sb_q.push_back({rd, exp});
    @(negedge clk);
    check("ld_rv_ready", {31'd0, exu_ready}, 32'd0);
    if (dep) check("ld_rv_stall", {31'd0, idu_stall}, 32'd1);
    tick();
    mem_rvalid  = 1'b0;
    exu_valid   = 1'b0;
    @(negedge clk);
    check("ld_done_ready", {31'd0, exu_ready}, 32'd1);
    if (dep) begin
      check("ld_done_stall", {31'd0, idu_stall}, {31'd0, !BYP});
      check("ld_done_hit", {31'd0, byp_rs1_hit}, {31'd0, BYP});
      if (BYP) check("ld_done_byp", byp_data, exp);
    end
    tick();
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    rst          = 1'b1;
    exu_valid    = 1'b0;
    exu_wen      = 1'b0;
    exu_rd       = 5'd0;
    exu_data     = 32'd0;
    exu_is_load  = 1'b0;
    exu_funct3   = 3'd0;
    exu_addr_lo  = 2'd0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'd0;
    idu_rs1_addr = 5'd0;
    idu_rs2_addr = 5'd0;
    tick();
    tick();
    @(negedge clk);
    check("rst_ready", {31'd0, exu_ready}, 32'd1);
    check("rst_we", {31'd0, reg_we}, 32'd0);
    check("rst_addr", {27'd0, reg_addr}, 32'd0);
    check("rst_data", reg_data, 32'd0);
    check("rst_stall", {31'd0, idu_stall}, 32'd0);
    check("rst_byp", byp_data, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ALU write with rs1 dependency in the write cycle
    idu_rs1_addr = 5'd5;
    issue(1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
    @(negedge clk);
    check("alu_we", {31'd0, reg_we}, 32'd1);
    check("alu_stall", {31'd0, idu_stall}, {31'd0, !BYP});
    check("alu_hit1", {31'd0, byp_rs1_hit}, {31'd0, BYP});
    tick();
    @(negedge clk);
    check("alu_we_pulse", {31'd0, reg_we}, 32'd0);
    check("alu_stall_clr", {31'd0, idu_stall}, 32'd0);
    idu_rs1_addr = 5'd0;

    // rd=0 never writes
    issue(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd0);
    @(negedge clk);
    check("rd0_we", {31'd0, reg_we}, 32'd0);
    tick();

    // back-to-back rs2 dependency
    idu_rs2_addr = 5'd20;
    issue(1'b1, 5'd20, 32'hA5A5_0001, 1'b0, 3'd0, 2'd0);
    @(negedge clk);
    check("rs2_stall", {31'd0, idu_stall}, {31'd0, !BYP});
    check("rs2_hit", {31'd0, byp_rs2_hit}, {31'd0, BYP});
    check("rs2_hit1", {31'd0, byp_rs1_hit}, 32'd0);
    tick();
    idu_rs2_addr = 5'd0;

    // wen=0 ALU op
    issue(1'b0, 5'd3, 32'h1111_1111, 1'b0, 3'd0, 2'd0);
    tick();

    // sub-word loads
    do_load(5'd10, 3'b000, 2'd3, 32'h80AA_BBCC, 0, 32'hFFFF_FF80);
    do_load(5'd11, 3'b100, 2'd3, 32'h80AA_BBCC, 0, 32'h0000_0080);
    do_load(5'd12, 3'b101, 2'd2, 32'h80AA_BBCC, 1, 32'h0000_80AA);
    do_load(5'd13, 3'b001, 2'd3, 32'h80AA_BBCC, 0, 32'hFFFF_80AA);
    do_load(5'd14, 3'b001, 2'd0, 32'h80AA_BBCC, 0, 32'hFFFF_BBCC);
    do_load(5'd15, 3'b000, 2'd1, 32'h80AA_BBCC, 2, 32'hFFFF_FFBB);
    do_load(5'd16, 3'b100, 2'd0, 32'h80AA_BBCC, 0, 32'h0000_00CC);
    do_load(5'd17, 3'b011, 2'd1, 32'h1234_8678, 0, 32'h1234_8678);
    do_load(5'd18, 3'b101, 2'd1, 32'h7FFF_8001, 0, 32'h0000_8001);
    do_load(5'd0,  3'b010, 2'd0, 32'hFFFF_FFFF, 0, 32'd0);

    // load-use hazard with slow memory
    idu_rs1_addr = 5'd7;
    do_load(5'd7, 3'b010, 2'd0, 32'hCAFE_F00D, 4, 32'hCAFE_F00D);
    @(negedge clk);
    check("ld7_stall_clr", {31'd0, idu_stall}, 32'd0);
    tick();

    // reset in the middle of a load
    idu_rs1_addr = 5'd12;
    issue(1'b1, 5'd12, 32'd0, 1'b1, 3'b010, 2'd0);
    @(negedge clk);
    check("mid_ready", {31'd0, exu_ready}, 32'd0);
    check("mid_stall", {31'd0, idu_stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, exu_ready}, 32'd1);
    check("rst_mid_stall", {31'd0, idu_stall}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_rv_we", {31'd0, reg_we}, 32'd0);
    check("stray_ready", {31'd0, exu_ready}, 32'd1);
    tick();
    tick();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
